pipe_idex_stage: RTL
====================

Name: pipe_idex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded instruction fields, register-file operands and control from ID. Drives the ID/EX state that the EX-stage ALU forwarding unit compares against EX/MEM and MEM/WB destinations.
- Inserts bubbles on load-use hazards, squashes on EX-resolved branches and holds on downstream EX stalls.

Parameters:
- DATA_W, 32, width of operand and immediate datapath.
- CNT_W, 16, width of bubble statistics counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  source register Rs
- id_rt  in  5  source register Rt
- id_rd  in  5  destination register, already selected by RegDst
- id_uses_rs  in  1  instruction reads Rs
- id_uses_rt  in  1  instruction reads Rt
- id_rs_data  in  DATA_W  register-file Rs value
- id_rt_data  in  DATA_W  register-file Rt value
- id_imm  in  DATA_W  sign-extended immediate
- id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc  in  1 each  control bits
- id_ALUOp  in  4  ALU operation
- ex_flush  in  1  branch/jump taken in EX; squash ID and ID/EX
- ex_hold  in  1  EX cannot accept a new instruction this cycle
- IDEX_valid  out  1  EX holds a real instruction
- IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd  out  5 each  registered register numbers
- IDEX_RsData, IDEX_RtData, IDEX_Imm  out  DATA_W each  registered operands
- IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc  out  1 each  registered control
- IDEX_ALUOp  out  4  registered ALU operation
- stall  out  1  freeze PC and IF/ID this cycle
- bubble_count  out  CNT_W  load-use bubbles inserted

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active-low on reset_n.
  - All registered outputs clear to 0 while reset_n=0 at a rising edge, including IDEX_valid=0 and bubble_count=0.
- Load-use hazard (combinational, from current ID/EX state and ID inputs):
  - Condition: luh = IDEX_valid & IDEX_MemRead & IDEX_RegisterRd!=0 & id_valid & (rs_hit | rt_hit_nonstore).
  - rs_hit = id_uses_rs & id_rs==IDEX_RegisterRd.
  - rt_hit_nonstore = id_uses_rt & id_rt==IDEX_RegisterRd & !id_MemWrite. A lw followed by sw whose only dependency is store data (Rt) does not stall; mem-to-mem forwarding covers it. If sw address (Rs) matches, stall.
- stall = !ex_flush & (ex_hold | luh). Combinational, zero latency.
- Register update, priority highest first, at each rising edge:
  1. !reset_n: clear all.
  2. ex_flush: load bubble (IDEX_valid=0, all control bits 0, ALUOp 0). Register numbers and data are don't-care; implementation zeroes them.
  3. ex_hold: retain all contents unchanged.
  4. luh: load bubble as in 2; bubble_count increments.
  5. Otherwise: capture all id_* fields; IDEX_valid=id_valid.
- Control gating: when id_valid=0, captured RegWrite/MemRead/MemWrite are forced 0.
- Latency: one cycle ID to EX. A stalled instruction re-presents in ID next cycle and captures when luh clears. A lw-use pair costs exactly one bubble.
- Counter: saturates at all-ones, no wrap. Counts only priority-4 bubbles, not flushes.
- Reset mid-stall: stall deasserts the cycle after reset is sampled, because IDEX_valid=0.

Optional Feature:
- Macro PIPE_IDEX_STATS_EN.
- Defined: bubble_count behaves as above.
- Undefined: counter logic is omitted and bubble_count is constant 0. Hazard and stall behaviour are identical in both builds.

Test Plan:
- lw $5 in ID/EX (MemRead=1, Rd=5); ID add with rs=5, uses_rs=1 -> stall=1 same cycle; next edge IDEX_valid=0, RegWrite=0, bubble_count=1. Following edge captures add with IDEX_RegisterRs=5.
- lw $5 in ID/EX; ID sw with rt=5, rs=3, MemWrite=1 -> stall=0; sw captured next edge, bubble_count stays 0. Same with rs=5 -> stall=1.
- lw $0 in ID/EX; ID add rs=0 -> stall=0, no bubble.
- ex_flush=1 with simultaneous luh -> stall=0; next edge IDEX_valid=0, bubble_count unchanged.
- ex_hold=1 for 3 cycles with add $7 in ID/EX -> stall=1 throughout, IDEX_RegisterRd=7 and data unchanged. On release, the ID instruction captures.
- reset_n=0 for one edge mid-stall -> all outputs 0, stall=0 next cycle. With PIPE_IDEX_STATS_EN and CNT_W=2, 4 bubbles -> bubble_count=3 (saturated).

Source files
------------

// File: rtl/pipe_idex_stage.sv
// ============================================================================
// pipe_idex_stage : ID/EX pipeline register with load-use hazard detection.
// Optional macro PIPE_IDEX_STATS_EN enables the bubble statistics counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_idex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic              id_ALUSrc,
  input  logic [3:0]        id_ALUOp,
  input  logic              ex_flush,
  input  logic              ex_hold,
  output logic              IDEX_valid,
  output logic [4:0]        IDEX_RegisterRs,
  output logic [4:0]        IDEX_RegisterRt,
  output logic [4:0]        IDEX_RegisterRd,
  output logic [DATA_W-1:0] IDEX_RsData,
  output logic [DATA_W-1:0] IDEX_RtData,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic              IDEX_MemtoReg,
  output logic              IDEX_ALUSrc,
  output logic [3:0]        IDEX_ALUOp,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic [3:0]        aluop;
  } idex_t;

  idex_t idex_q, idex_d, id_cap;
  logic  rs_hit, rt_hit_nonstore, luh, bubble_ins;

  always_comb begin
    rs_hit          = id_uses_rs & (id_rs == idex_q.rd);
    // A store whose only dependency is its data operand is served by mem-to-mem forwarding.
    rt_hit_nonstore = id_uses_rt & (id_rt == idex_q.rd) & ~id_MemWrite;
    luh             = idex_q.valid & idex_q.memread & (idex_q.rd != 5'd0) &
                      id_valid & (rs_hit | rt_hit_nonstore);
    stall           = ~ex_flush & (ex_hold | luh);
    bubble_ins      = ~ex_flush & ~ex_hold & luh;
  end

  always_comb begin
    id_cap          = '0;
    id_cap.valid    = id_valid;
    id_cap.rs       = id_rs;
    id_cap.rt       = id_rt;
    id_cap.rd       = id_rd;
    id_cap.rs_data  = id_rs_data;
    id_cap.rt_data  = id_rt_data;
    id_cap.imm      = id_imm;
    id_cap.regwrite = id_RegWrite & id_valid;
    id_cap.memread  = id_MemRead & id_valid;
    id_cap.memwrite = id_MemWrite & id_valid;
    id_cap.memtoreg = id_MemtoReg;
    id_cap.alusrc   = id_ALUSrc;
    id_cap.aluop    = id_ALUOp;
  end

  always_comb begin
    idex_d = idex_q;
    if (ex_flush) begin
      idex_d = '0;
    end else if (ex_hold) begin
      idex_d = idex_q;
    end else if (luh) begin
      idex_d = '0;
    end else begin
      idex_d = id_cap;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

`ifdef PIPE_IDEX_STATS_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_ins && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_count = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble_ins;
  assign bubble_count  = {CNT_W{1'b0}};
`endif

  assign IDEX_valid      = idex_q.valid;
  assign IDEX_RegisterRs = idex_q.rs;
  assign IDEX_RegisterRt = idex_q.rt;
  assign IDEX_RegisterRd = idex_q.rd;
  assign IDEX_RsData     = idex_q.rs_data;
  assign IDEX_RtData     = idex_q.rt_data;
  assign IDEX_Imm        = idex_q.imm;
  assign IDEX_RegWrite   = idex_q.regwrite;
  assign IDEX_MemRead    = idex_q.memread;
  assign IDEX_MemWrite   = idex_q.memwrite;
  assign IDEX_MemtoReg   = idex_q.memtoreg;
  assign IDEX_ALUSrc     = idex_q.alusrc;
  assign IDEX_ALUOp      = idex_q.aluop;

endmodule

`default_nettype wire
